// File: rtl/axi_rorder_s3.sv
// ---------------------------------------------------------------------------
// axi_rorder_s3
//
// Read-ordering tracker for one master port. Every accepted AR burst has its
// decoded target slave recorded in a small FIFO. The R-channel response mux is
// enabled only for the slave that owns the oldest outstanding burst, so read
// data comes back to the master in the order the bursts were issued.
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   M_ARVALID/M_ARREADY AR handshake with the master (already decoded)
//   AR_SLV              decoded target of the current AR (3 = default slave)
//   S_ARVALID/S_ARREADY AR handshake toward the selected slave path
//   M_RVALID/M_RREADY   R handshake at the master port
//   M_RLAST, R_SRC      last-beat flag and encoded source of the current beat
//   r_order_grant       one-hot R enable for S0..S2 (default slave not gated)
//   OUT_CNT             number of outstanding bursts held in the FIFO
//   ORD_ERR             sticky flag for any out-of-order response
// ---------------------------------------------------------------------------
module axi_rorder_s3 #(
  parameter int DEPTH     = 8,
  parameter int WIDTH_CNT = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 M_ARVALID,
  output logic                 M_ARREADY,
  input  logic [1:0]           AR_SLV,
  output logic                 S_ARVALID,
  input  logic                 S_ARREADY,
  input  logic                 M_RVALID,
  input  logic                 M_RREADY,
  input  logic                 M_RLAST,
  input  logic [1:0]           R_SRC,
  output logic [2:0]           r_order_grant,
  output logic [WIDTH_CNT-1:0] OUT_CNT,
  output logic                 ORD_ERR
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]           r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rptr;
  logic [PTR_W-1:0]     r_wptr;
  logic [WIDTH_CNT-1:0] r_cnt;
  logic                 r_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rHs;
  logic                 w_lastHs;
  logic [1:0]           w_head;
  logic [2:0]           w_grant;
  logic                 w_srcBlocked;
  logic                 w_viol;

  assign w_full  = (r_cnt == WIDTH_CNT'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_mem[r_rptr];

  // Full comes from the registered count, so a pop in the same cycle does not
  // reopen the AR path until the next cycle.
  assign S_ARVALID = M_ARVALID & ~w_full & ~ARESET;
  assign M_ARREADY = S_ARREADY & ~w_full & ~ARESET;

  assign w_push   = M_ARVALID & M_ARREADY;
  assign w_rHs    = M_RVALID & M_RREADY;
  assign w_lastHs = w_rHs & M_RLAST;
  assign w_pop    = w_lastHs & ~w_empty & (R_SRC == w_head);

  // Grant follows the head entry; the default slave (3) is always enabled by
  // the mux itself, so it maps to no grant bit.
  always_comb begin
    w_grant = 3'b000;
    if (!w_empty) begin
      case (w_head)
        2'd0:    w_grant = 3'b001;
        2'd1:    w_grant = 3'b010;
        2'd2:    w_grant = 3'b100;
        default: w_grant = 3'b000;
      endcase
    end
  end

  assign r_order_grant = w_grant;

  // A beat from a real slave whose enable is off means the mux let through a
  // response that should have been held back.
  always_comb begin
    w_srcBlocked = 1'b0;
    case (R_SRC)
      2'd0:    w_srcBlocked = ~w_grant[0];
      2'd1:    w_srcBlocked = ~w_grant[1];
      2'd2:    w_srcBlocked = ~w_grant[2];
      default: w_srcBlocked = 1'b0;
    endcase
  end

  assign w_viol = (w_lastHs & (w_empty | (R_SRC != w_head))) |
                  (w_rHs & w_srcBlocked);

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= AR_SLV;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. Count is held
  // when a push and a pop land in the same cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + WIDTH_CNT'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - WIDTH_CNT'(1);
      end
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  assign OUT_CNT = r_cnt;
  assign ORD_ERR = r_err;

endmodule

// File: tb/tb_axi_rorder_s3.sv
// ---------------------------------------------------------------------------
// tb_axi_rorder_s3
//
// Table-driven bench for the read-ordering tracker. Each vector drives one
// cycle of AR/R inputs, checks the combinational AR gating before the edge and
// the registered grant/count/error after it. A queue of issued slave IDs
// predicts which slave must be granted when a burst completes.
// ---------------------------------------------------------------------------
module tb_axi_rorder_s3;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       M_ARVALID;
  logic       M_ARREADY;
  logic [1:0] AR_SLV;
  logic       S_ARVALID;
  logic       S_ARREADY;
  logic       M_RVALID;
  logic       M_RREADY;
  logic       M_RLAST;
  logic [1:0] R_SRC;
  logic [2:0] r_order_grant;
  logic [3:0] OUT_CNT;
  logic       ORD_ERR;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] sbQ [$];

  typedef struct {
    logic       rst;
    logic       arv;
    logic [1:0] slv;
    logic       sar;
    logic       rv;
    logic       rl;
    logic [1:0] src;
    logic       eAr;
    logic       eSv;
    logic [2:0] eG;
    logic [3:0] eC;
    logic       eE;
  } vec_t;

  vec_t vecs [$];

  axi_rorder_s3 #(.DEPTH(8), .WIDTH_CNT(4)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .M_ARVALID     (M_ARVALID),
    .M_ARREADY     (M_ARREADY),
    .AR_SLV        (AR_SLV),
    .S_ARVALID     (S_ARVALID),
    .S_ARREADY     (S_ARREADY),
    .M_RVALID      (M_RVALID),
    .M_RREADY      (M_RREADY),
    .M_RLAST       (M_RLAST),
    .R_SRC         (R_SRC),
    .r_order_grant (r_order_grant),
    .OUT_CNT       (OUT_CNT),
    .ORD_ERR       (ORD_ERR)
  );

  always #5 ACLK = ~ACLK;

  function automatic vec_t mk(input logic rst, input logic arv, input logic [1:0] slv,
                              input logic sar, input logic rv, input logic rl,
                              input logic [1:0] src, input logic eAr, input logic eSv,
                              input logic [2:0] eG, input logic [3:0] eC, input logic eE);
    vec_t v;
    v.rst = rst; v.arv = arv; v.slv = slv; v.sar = sar;
    v.rv  = rv;  v.rl  = rl;  v.src = src;
    v.eAr = eAr; v.eSv = eSv; v.eG  = eG;  v.eC = eC; v.eE = eE;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [2:0] sbGrant;
    @(negedge ACLK);
    ARESET    = v.rst;
    M_ARVALID = v.arv;
    AR_SLV    = v.slv;
    S_ARREADY = v.sar;
    M_RVALID  = v.rv;
    M_RREADY  = v.rv;
    M_RLAST   = v.rl;
    R_SRC     = v.src;
    #1;
    checkOutput({tag, ".arready"}, 32'(M_ARREADY), 32'(v.eAr));
    checkOutput({tag, ".sarvalid"}, 32'(S_ARVALID), 32'(v.eSv));
    if (v.rst) begin
      sbQ.delete();
    end else begin
      if (v.rv && v.rl && sbQ.size() > 0 && sbQ[0] == v.src) begin
        sbGrant = (sbQ[0] == 2'd3) ? 3'b000 : (3'b001 << sbQ[0]);
        checkOutput({tag, ".sbGrant"}, 32'(r_order_grant), 32'(sbGrant));
        void'(sbQ.pop_front());
      end
      if (v.arv && v.eAr) begin
        sbQ.push_back(v.slv);
      end
    end
    @(posedge ACLK);
    #1;
    checkOutput({tag, ".grant"}, 32'(r_order_grant), 32'(v.eG));
    checkOutput({tag, ".cnt"}, 32'(OUT_CNT), 32'(v.eC));
    checkOutput({tag, ".err"}, 32'(ORD_ERR), 32'(v.eE));
    checkOutput({tag, ".sbCount"}, 32'(OUT_CNT), 32'(sbQ.size()));
  endtask

  initial begin
    ARESET = 1'b1; M_ARVALID = 1'b0; AR_SLV = 2'd0; S_ARREADY = 1'b0;
    M_RVALID = 1'b0; M_RREADY = 1'b0; M_RLAST = 1'b0; R_SRC = 2'd0;

    //          rst arv slv sar rv rl src eAr eSv eG      eC  eE
    // Reset with AR pending: AR gated off while in reset.
    vecs.push_back(mk(1, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 3'b000, 4'd0, 0));
    // Idle: M_ARREADY follows S_ARREADY.
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 3'b000, 4'd0, 0));
    vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 2'd0, 1, 0, 3'b000, 4'd0, 0));
    // AR to S1, S0, S2.
    vecs.push_back(mk(0, 1, 2'd1, 1, 0, 0, 2'd0, 1, 1, 3'b010, 4'd1, 0));
    vecs.push_back(mk(0, 1, 2'd0, 1, 0, 0, 2'd0, 1, 1, 3'b010, 4'd2, 0));
    vecs.push_back(mk(0, 1, 2'd2, 1, 0, 0, 2'd0, 1, 1, 3'b010, 4'd3, 0));
    // S1 returns 4 beats; only the last pops.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 2'd0, 0, 1, 0, 2'd1, 0, 0, 3'b010, 4'd3, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd1, 0, 0, 3'b001, 4'd2, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 3'b100, 4'd1, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd2, 0, 0, 3'b000, 4'd0, 0));
    // Fill to DEPTH with targets 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 2'(i % 4), 1, 0, 0, 2'd0, 1, 1, 3'b001, 4'(i + 1), 0));
    // Ninth AR blocked while full.
    vecs.push_back(mk(0, 1, 2'd2, 1, 0, 0, 2'd0, 0, 0, 3'b001, 4'd8, 0));
    // Pop while full: still not ready this cycle, ready next cycle.
    vecs.push_back(mk(0, 1, 2'd2, 1, 1, 1, 2'd0, 0, 0, 3'b010, 4'd7, 0));
    vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 2'd0, 1, 0, 3'b010, 4'd7, 0));
    // Drain 1,2,3,0,1,2,3.
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd1, 0, 0, 3'b100, 4'd6, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd2, 0, 0, 3'b000, 4'd5, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd3, 0, 0, 3'b001, 4'd4, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 3'b010, 4'd3, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd1, 0, 0, 3'b100, 4'd2, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd2, 0, 0, 3'b000, 4'd1, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd3, 0, 0, 3'b000, 4'd0, 0));
    // Count 1 with simultaneous S2 RLAST and new AR to S0.
    vecs.push_back(mk(0, 1, 2'd2, 1, 0, 0, 2'd0, 1, 1, 3'b100, 4'd1, 0));
    vecs.push_back(mk(0, 1, 2'd0, 1, 1, 1, 2'd2, 1, 1, 3'b001, 4'd1, 0));
    // Wrong-source RLAST: error, no pop.
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd1, 0, 0, 3'b001, 4'd1, 1));
    // Correct pop afterwards; error stays sticky.
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 3'b000, 4'd0, 1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 3'b000, 4'd0, 0));
    // Non-last beat from an ungranted slave also flags an error.
    vecs.push_back(mk(0, 1, 2'd0, 1, 0, 0, 2'd0, 1, 1, 3'b001, 4'd1, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 1, 0, 2'd2, 0, 0, 3'b001, 4'd1, 1));
    vecs.push_back(mk(1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 3'b000, 4'd0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Wrap the write pointer past DEPTH-1 with 5 outstanding, then reset.
    for (int k = 0; k < 6; k++)
      applyStimulus(mk(0, 1, 2'(k % 3), 1, 0, 0, 2'd0, 1, 1, 3'b001, 4'(k + 1), 0),
                    $sformatf("wrapPush%0d", k));
    applyStimulus(mk(0, 0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 3'b010, 4'd5, 0), "wrapPop0");
    applyStimulus(mk(0, 0, 2'd0, 0, 1, 1, 2'd1, 0, 0, 3'b100, 4'd4, 0), "wrapPop1");
    applyStimulus(mk(0, 0, 2'd0, 0, 1, 1, 2'd2, 0, 0, 3'b001, 4'd3, 0), "wrapPop2");
    applyStimulus(mk(0, 0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 3'b010, 4'd2, 0), "wrapPop3");
    applyStimulus(mk(0, 1, 2'd2, 1, 0, 0, 2'd0, 1, 1, 3'b010, 4'd3, 0), "wrapPush6");
    applyStimulus(mk(0, 1, 2'd3, 1, 0, 0, 2'd0, 1, 1, 3'b010, 4'd4, 0), "wrapPush7");
    applyStimulus(mk(0, 1, 2'd1, 1, 0, 0, 2'd0, 1, 1, 3'b010, 4'd5, 0), "wrapPush8");
    applyStimulus(mk(1, 1, 2'd1, 1, 0, 0, 2'd0, 0, 0, 3'b000, 4'd0, 0), "wrapReset");
    // Default-slave burst: grant stays 000 until its RLAST.
    applyStimulus(mk(0, 1, 2'd3, 1, 0, 0, 2'd0, 1, 1, 3'b000, 4'd1, 0), "sdPush");
    applyStimulus(mk(0, 0, 2'd0, 0, 1, 0, 2'd3, 0, 0, 3'b000, 4'd1, 0), "sdBeat");
    applyStimulus(mk(0, 0, 2'd0, 0, 1, 1, 2'd3, 0, 0, 3'b000, 4'd0, 0), "sdLast");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
